store_rmw_merger: RTL and testbench



---
 rtl/store_rmw_merger_if.sv | 28 ++
 rtl/store_rmw_merger.sv | 104 ++++++++++
 tb/tb_store_rmw_merger.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/store_rmw_merger_if.sv
// Store request port plus word-wide data RAM port for the store read-modify-write merger.
// The slave modport is the merger side; the master modport is the datapath/RAM side.
interface store_rmw_merger_if #(
    parameter int ADDR_W = 30
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              done;
    logic              misalign_err;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_size, mem_rdata,
        output req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, misalign_err
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_size, mem_rdata,
        input  req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, misalign_err
    );
endinterface

// File: rtl/store_rmw_merger.sv
// Narrows byte/half stores and merges them into a word RAM without byte enables via read-modify-write.
// Latency: sub-word write at T+3, word write at T+1, misalign error pulse at T+1 after accept.
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored, not queued.
module store_rmw_merger #(
    parameter int ADDR_W     = 30,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    store_rmw_merger_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [15:0] wdata;
        logic [1:0]  size;
        logic [1:0]  lane;
    } req_t;

    logic [2:0]        state;
    req_t              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic [31:0]       merged;
    logic [1:0]        lane_d;
    logic              misaligned;

    // Halfword lane is held in lane[0]; byte lane uses both bits.
    always_comb begin
        lane_d = bus.req_addr[1:0] ^ {2{BIG_ENDIAN}};
        if (bus.req_size == SZ_HALF) begin
            lane_d = {1'b0, bus.req_addr[1] ^ BIG_ENDIAN};
        end
    end

    always_comb begin
        case (bus.req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_WORD: misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        merged = bus.mem_rdata;
        if (req_q.size == SZ_BYTE) begin
            merged[{req_q.lane, 3'b000} +: 8] = req_q.wdata[7:0];
        end else begin
            merged[{req_q.lane[0], 4'b0000} +: 16] = req_q.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            merge_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr[ADDR_W+1:2];
                        req_q  <= '{wdata: bus.req_wdata[15:0], size: bus.req_size, lane: lane_d};
                        if (misaligned) begin
                            state <= ERR;
                        end else if (bus.req_size == SZ_WORD) begin
                            // Full word needs no read; preload the write word directly.
                            merge_q <= bus.req_wdata;
                            state   <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ:  state <= WAIT;
                WAIT: begin
                    merge_q <= merged;
                    state   <= WRITE;
                end
                WRITE: state <= IDLE;
                ERR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.mem_rd_en    = (state == READ);
    assign bus.mem_wr_en    = (state == WRITE);
    assign bus.done         = (state == WRITE);
    assign bus.misalign_err = (state == ERR);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = merge_q;
endmodule

// File: tb/tb_store_rmw_merger.sv
// Directed bench for store_rmw_merger: one little-endian and one big-endian instance driven in lockstep.
module tb_store_rmw_merger;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [31:0] rd_word = 32'h0;

    store_rmw_merger_if #(.ADDR_W(30)) bus_le ();
    store_rmw_merger_if #(.ADDR_W(30)) bus_be ();

    store_rmw_merger #(.ADDR_W(30), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst(rst), .bus(bus_le));
    store_rmw_merger #(.ADDR_W(30), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst(rst), .bus(bus_be));

    always #5 clk = ~clk;

    // RAM model: data appears the cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        bus_le.mem_rdata <= bus_le.mem_rd_en ? rd_word : 32'h5A5A_5A5A;
        bus_be.mem_rdata <= bus_be.mem_rd_en ? rd_word : 32'hA5A5_A5A5;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size);
        bus_le.req_valid = vld;  bus_be.req_valid = vld;
        bus_le.req_addr  = addr; bus_be.req_addr  = addr;
        bus_le.req_wdata = wdata; bus_be.req_wdata = wdata;
        bus_le.req_size  = size; bus_be.req_size  = size;
    endtask

    task automatic sub_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic [31:0] rdw,
                             input logic [31:0] exp_le, input logic [31:0] exp_be);
        rd_word = rdw;
        drive(1'b1, addr, wdata, size);
        check({tag, "_ready_T"}, 32'(bus_le.req_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check({tag, "_rd_T1"},   32'(bus_le.mem_rd_en), 32'd1);
        check({tag, "_wr_T1"},   32'(bus_le.mem_wr_en), 32'd0);
        check({tag, "_addr_T1"}, 32'(bus_le.mem_addr), {2'b00, addr[31:2]});
        check({tag, "_rdy_T1"},  32'(bus_le.req_ready), 32'd0);
        tick();
        check({tag, "_rd_T2"},   32'(bus_le.mem_rd_en), 32'd0);
        check({tag, "_wr_T2"},   32'(bus_le.mem_wr_en), 32'd0);
        tick();
        check({tag, "_wr_T3"},   32'(bus_le.mem_wr_en), 32'd1);
        check({tag, "_done_T3"}, 32'(bus_le.done), 32'd1);
        check({tag, "_wd_le"},   bus_le.mem_wdata, exp_le);
        check({tag, "_wd_be"},   bus_be.mem_wdata, exp_be);
        check({tag, "_addr_T3"}, 32'(bus_le.mem_addr), {2'b00, addr[31:2]});
        tick();
        check({tag, "_rdy_T4"},  32'(bus_le.req_ready), 32'd1);
        check({tag, "_wr_T4"},   32'(bus_le.mem_wr_en), 32'd0);
    endtask

    task automatic mis_store(input string tag, input logic [31:0] addr, input logic [1:0] size);
        drive(1'b1, addr, 32'h1234_5678, size);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check({tag, "_err_T1"}, 32'(bus_le.misalign_err), 32'd1);
        check({tag, "_err_be"}, 32'(bus_be.misalign_err), 32'd1);
        check({tag, "_rd_T1"},  32'(bus_le.mem_rd_en), 32'd0);
        check({tag, "_wr_T1"},  32'(bus_le.mem_wr_en), 32'd0);
        check({tag, "_rdy_T1"}, 32'(bus_le.req_ready), 32'd0);
        tick();
        check({tag, "_rdy_T2"}, 32'(bus_le.req_ready), 32'd1);
        check({tag, "_err_T2"}, 32'(bus_le.misalign_err), 32'd0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #1;
        check("rst_ready", 32'(bus_le.req_ready), 32'd1);
        check("rst_rd",    32'(bus_le.mem_rd_en), 32'd0);
        check("rst_wr",    32'(bus_le.mem_wr_en), 32'd0);
        check("rst_done",  32'(bus_le.done), 32'd0);
        check("rst_err",   32'(bus_le.misalign_err), 32'd0);
        check("rst_addr",  32'(bus_le.mem_addr), 32'h0);
        check("rst_wdata", bus_le.mem_wdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        sub_store("byte", 32'h0000_0102, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 32'h11AB_3344, 32'h1122_AB44);
        sub_store("half", 32'h0000_0012, 32'h0000_BEEF, 2'b01, 32'hAAAA_5555, 32'hBEEF_5555, 32'hAAAA_BEEF);
        sub_store("byte0", 32'h0000_0FFC, 32'h0000_0077, 2'b00, 32'hCAFE_F00D, 32'hCAFE_F077, 32'h77FE_F00D);

        // Word store skips the read phase entirely.
        drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("word_rd_T1",   32'(bus_le.mem_rd_en), 32'd0);
        check("word_wr_T1",   32'(bus_le.mem_wr_en), 32'd1);
        check("word_done_T1", 32'(bus_le.done), 32'd1);
        check("word_addr_T1", 32'(bus_le.mem_addr), 32'h8);
        check("word_wd_le",   bus_le.mem_wdata, 32'hDEAD_BEEF);
        check("word_wd_be",   bus_be.mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("word_rdy_T2",  32'(bus_le.req_ready), 32'd1);
        check("word_wr_T2",   32'(bus_le.mem_wr_en), 32'd0);

        mis_store("mis_half", 32'h0000_0003, 2'b01);
        mis_store("mis_word", 32'h0000_0002, 2'b10);
        mis_store("mis_rsvd", 32'h0000_0000, 2'b11);

        // Continuous req_valid: accepts land every fourth cycle.
        rd_word = 32'h0102_0304;
        drive(1'b1, 32'h0000_0005, 32'h0000_00EE, 2'b00);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_rdy_%0d", i), 32'(bus_le.req_ready), 32'((i % 4) == 0));
            check($sformatf("b2b_wr_%0d", i),  32'(bus_le.mem_wr_en), 32'((i % 4) == 3));
            if ((i % 4) == 3) check($sformatf("b2b_wd_%0d", i), bus_le.mem_wdata, 32'h0102_EE04);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("b2b_idle", 32'(bus_le.req_ready), 32'd1);
        tick();
        check("b2b_noacc", 32'(bus_le.req_ready), 32'd1);

        // Reset asserted in WAIT aborts the store.
        rd_word = 32'h9999_9999;
        drive(1'b1, 32'h0000_0102, 32'h0000_0042, 2'b00);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        tick();
        rst = 1'b1;
        #1;
        check("abort_wr",    32'(bus_le.mem_wr_en), 32'd0);
        check("abort_done",  32'(bus_le.done), 32'd0);
        check("abort_rd",    32'(bus_le.mem_rd_en), 32'd0);
        check("abort_addr",  32'(bus_le.mem_addr), 32'h0);
        check("abort_wdata", bus_le.mem_wdata, 32'h0);
        check("abort_rdy",   32'(bus_le.req_ready), 32'd1);
        tick();
        check("abort_wr_hold", 32'(bus_le.mem_wr_en), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_wr_after_%0d", i), 32'(bus_le.mem_wr_en), 32'd0);
            check($sformatf("abort_rdy_after_%0d", i), 32'(bus_le.req_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
